// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: latches GPIO edge events into pending bits and raises one vectored irq at a time
module gpio_irq_ctrl #(
    parameter int NUM_IO  = 32,
    parameter int IDW     = 5,
    parameter int HOLDOFF = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IO-1:0] io_in_rise,
    input  logic [NUM_IO-1:0] io_in_fall,
    input  logic              stb,
    output logic              ack,
    input  logic              rw,
    input  logic [2:0]        addr,
    input  logic [31:0]       dwrite,
    output logic [31:0]       dtr,
    output logic              irq,
    output logic [IDW-1:0]    irq_vec,
    input  logic              irq_ack
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

    state_t            r_state;
    logic              r_irq;
    logic [IDW-1:0]    r_vec;
    logic [3:0]        r_cnt;
    logic [NUM_IO-1:0] r_en_r;
    logic [NUM_IO-1:0] r_en_f;
    logic [NUM_IO-1:0] r_pend;
    logic [NUM_IO-1:0] r_mask;

    logic              w_wr;
    logic              w_wd;
    logic              w_take;
    logic [NUM_IO-1:0] w_wdata;
    logic [NUM_IO-1:0] w_w1c;
    logic [NUM_IO-1:0] w_vec_bit;
    logic [NUM_IO-1:0] w_ack_clr;
    logic [NUM_IO-1:0] w_act;
    logic [IDW-1:0]    w_low;

    assign w_wr      = stb & rw;
    assign w_wdata   = dwrite[NUM_IO-1:0];
    assign w_w1c     = (w_wr && addr == 3'd2) ? w_wdata : '0;
    assign w_vec_bit = NUM_IO'(1) << r_vec;
    // software clearing the requested bit withdraws the request and swallows a same-cycle ack
    assign w_wd      = (r_state == REQ) && |(w_w1c & w_vec_bit);
    assign w_take    = (r_state == REQ) && irq_ack && !w_wd;
    assign w_ack_clr = w_take ? w_vec_bit : '0;
    assign w_act     = r_pend & ~r_mask;

    always_comb begin
        w_low = '0;
        for (int i = NUM_IO - 1; i >= 0; i--)
            if (w_act[i]) w_low = IDW'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en_r <= '0;
            r_en_f <= '0;
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_pend <= (r_pend & ~(w_w1c | w_ack_clr)) | (io_in_rise & r_en_r) | (io_in_fall & r_en_f);
            if (w_wr && addr == 3'd0) r_en_r <= w_wdata;
            if (w_wr && addr == 3'd1) r_en_f <= w_wdata;
            if (w_wr && addr == 3'd3) r_mask <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_vec   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (|w_act) begin
                    r_vec   <= w_low;
                    r_irq   <= 1'b1;
                    r_state <= REQ;
                end
                REQ: if (w_wd || w_take) begin
                    r_irq   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= (w_take && HOLDOFF != 0) ? HOLD : IDLE;
                end
                HOLD: if (r_cnt == 4'(HOLDOFF - 1)) r_state <= IDLE;
                      else r_cnt <= r_cnt + 4'd1;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack     = stb;
    assign irq     = r_irq;
    assign irq_vec = r_vec;

    always_comb begin
        dtr = addr == 3'd0 ? 32'(r_en_r) :
              addr == 3'd1 ? 32'(r_en_f) :
              addr == 3'd2 ? 32'(r_pend) :
              addr == 3'd3 ? 32'(r_mask) :
              addr == 3'd4 ? {24'b0, r_irq, r_state, 5'(r_vec)} : 32'd0;
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed and random stimulus checked against a behavioural model
module tb_gpio_irq_ctrl;
    localparam int NIO     = 32;
    localparam int HOLDOFF = 2;

    logic        clk = 0, reset = 0, stb = 0, rw = 0, irq_ack = 0;
    logic [31:0] rise = 0, fall = 0, dwrite = 0;
    logic [2:0]  addr = 0;
    logic        ack, irq;
    logic [31:0] dtr;
    logic [4:0]  irq_vec;

    int n_chk = 0, n_err = 0;

    logic [31:0] m_enr, m_enf, m_pend, m_mask;
    int          m_st, m_hold;
    logic        m_irq;
    logic [4:0]  m_vec;

    gpio_irq_ctrl #(.NUM_IO(NIO), .IDW(5), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .reset(reset), .io_in_rise(rise), .io_in_fall(fall),
        .stb(stb), .ack(ack), .rw(rw), .addr(addr), .dwrite(dwrite), .dtr(dtr),
        .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mreg(input logic [2:0] a);
        case (a)
            3'd0: return m_enr;
            3'd1: return m_enf;
            3'd2: return m_pend;
            3'd3: return m_mask;
            3'd4: return {24'b0, m_irq, 2'(m_st), m_vec};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_enr = 0; m_enf = 0; m_pend = 0; m_mask = 0;
        m_st = 0; m_hold = 0; m_irq = 0; m_vec = 0;
    endtask

    // one clock of the spec's rules, evaluated on the inputs currently driven
    task automatic model_step();
        logic [31:0] w1c, clr, act, lsb;
        w1c = (stb && rw && addr == 3'd2) ? dwrite : 32'd0;
        clr = 0;
        if (m_st == 0) begin
            act = m_pend & ~m_mask;
            if (act != 0) begin
                lsb   = act & (~act + 32'd1);
                m_vec = 5'($clog2(lsb));
                m_irq = 1;
                m_st  = 1;
            end
        end else if (m_st == 1) begin
            if (w1c[m_vec]) begin
                m_irq = 0;
                m_st  = 0;
            end else if (irq_ack) begin
                clr[m_vec] = 1'b1;
                m_irq  = 0;
                m_hold = HOLDOFF;
                m_st   = (HOLDOFF > 0) ? 2 : 0;
            end
        end else begin
            m_hold--;
            if (m_hold == 0) m_st = 0;
        end
        m_pend = (m_pend & ~(w1c | clr)) | (rise & m_enr) | (fall & m_enf);
        if (stb && rw) begin
            if (addr == 3'd0) m_enr = dwrite;
            if (addr == 3'd1) m_enf = dwrite;
            if (addr == 3'd3) m_mask = dwrite;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq", irq, m_irq);
        chk("irq_vec", irq_vec, m_vec);
        chk("dtr", dtr, mreg(addr));
        chk("ack", ack, stb);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, dtr, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; dwrite = d; stb = 1; rw = 1;
        tick();
        stb = 0; rw = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_vec", irq_vec, 0);
        for (int a = 0; a < 8; a++) rd(3'(a), 0, "rst_reg");
        stb = 1;
        #1;
        chk("rst_ack", ack, 1);
        stb = 0;
        reset = 1;

        // rise on pin 0, ack, then holdoff
        wr(0, 32'h1);
        rise = 32'h1; tick(); rise = 0;
        rd(2, 32'h1, "t2_pend");
        chk("t2_irq_early", irq, 0);
        tick();
        chk("t2_irq", irq, 1);
        chk("t2_vec", irq_vec, 0);
        irq_ack = 1; tick(); irq_ack = 0;
        rd(2, 0, "t2_pend_clr");
        chk("t2_irq_drop", irq, 0);
        rd(4, 32'h40, "t2_hold1");
        tick(); rd(4, 32'h40, "t2_hold2");
        tick(); rd(4, 32'h0, "t2_idle");

        // masked lower pin skipped, then served after unmask
        wr(1, 32'hFFFF_FFFF);
        wr(3, 32'h8);
        fall = (32'h1 << 3) | (32'h1 << 9); tick(); fall = 0;
        tick();
        chk("t3_irq", irq, 1);
        chk("t3_vec9", irq_vec, 9);
        wr(3, 0);
        chk("t3_mask_keep", irq, 1);
        irq_ack = 1; tick(); irq_ack = 0;
        repeat (3) tick();
        chk("t3_irq2", irq, 1);
        chk("t3_vec3", irq_vec, 3);
        irq_ack = 1; tick(); irq_ack = 0;
        repeat (3) tick();

        // withdraw by W1C with a coincident ack
        fall = 32'h1 << 5; tick(); fall = 0;
        tick();
        chk("t4_vec5", irq_vec, 5);
        addr = 2; dwrite = 32'h20; stb = 1; rw = 1; irq_ack = 1;
        tick();
        stb = 0; rw = 0; irq_ack = 0;
        chk("t4_irq", irq, 0);
        rd(4, 32'h5, "t4_stat_idle");
        rd(2, 0, "t4_pend");
        tick();
        chk("t4_irq_after", irq, 0);

        // new event beats a same-cycle clear
        wr(3, 32'hFFFF_FFFF);
        wr(0, 32'h80);
        rise = 32'h80; tick(); rise = 0;
        rd(2, 32'h80, "t5_pend_set");
        addr = 2; dwrite = 32'h80; stb = 1; rw = 1; rise = 32'h80;
        tick();
        stb = 0; rw = 0; rise = 0;
        rd(2, 32'h80, "t5_pend_keep");
        wr(2, 32'h80);
        rd(2, 0, "t5_clear");

        // writes to STAT and unused addresses are ignored
        for (int a = 4; a < 8; a++) wr(3'(a), 32'hFFFF_FFFF);
        rd(0, 32'h80, "t6_enr");
        rd(1, 32'hFFFF_FFFF, "t6_enf");
        rd(3, 32'hFFFF_FFFF, "t6_mask");
        rd(4, 32'h5, "t6_stat");
        for (int a = 5; a < 8; a++) rd(3'(a), 0, "t6_unused");

        wr(3, 0);
        for (int k = 0; k < 600; k++) begin
            rise    = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            fall    = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            irq_ack = ($urandom_range(0, 3) == 0);
            stb     = ($urandom_range(0, 4) == 0);
            rw      = stb && ($urandom_range(0, 1) == 1);
            addr    = 3'($urandom_range(0, 7));
            dwrite  = ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << $urandom_range(0, 31));
            tick();
        end
        stb = 0; rw = 0; irq_ack = 0; rise = 0; fall = 0;

        // async reset while a request is outstanding
        wr(3, 0);
        wr(0, 32'h1);
        rise = 32'h1; tick(); rise = 0;
        for (int k = 0; k < 12 && !irq; k++) tick();
        chk("t1_req", irq, 1);
        #3 reset = 0;
        #1;
        chk("t1_irq", irq, 0);
        chk("t1_vec", irq_vec, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        for (int a = 0; a < 8; a++) rd(3'(a), 0, "t1_reg");
        tick();
        chk("t1_idle", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
